// File: rtl/hazard_stall_ctrl.sv
// Hazard and stall controller for the five-stage MIPS32 pipeline: load-use,
// taken-branch flush, I-mem wait states, divide interlock, stall-cycle counter.
module hazard_stall_ctrl #(
  parameter int unsigned DIV_CYCLES = 32,
  parameter int unsigned CNT_W      = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rs,
  input  logic             id_uses_rt,
  input  logic             id_is_div,
  input  logic             ex_mem_read,
  input  logic [4:0]       ex_rt,
  input  logic             ex_branch_taken,
  input  logic             imem_ready,
  input  logic             perf_clear,
  output logic             pc_hold,
  output logic             ifid_hold,
  output logic             ifid_flush,
  output logic             idex_bubble,
  output logic             div_busy,
  output logic             div_done,
  output logic [CNT_W-1:0] stall_count
);

  typedef enum logic {RUN, DIV_WAIT} state_e;

  localparam logic [7:0] DIV_CNT_INIT = 8'(DIV_CYCLES - 1);

  state_e             state_q, state_d;
  logic [7:0]         div_cnt_q, div_cnt_d;
  logic [CNT_W-1:0]   stall_count_q, stall_count_d;
  logic               load_use;

  // $0 is hard-wired zero, so a load targeting it never creates a dependency.
  assign load_use = ex_mem_read && (ex_rt != 5'd0) &&
                    ((id_uses_rs && (id_rs == ex_rt)) ||
                     (id_uses_rt && (id_rt == ex_rt)));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= RUN;
      div_cnt_q <= '0;
    end else begin
      // NOTE: non-blocking assignments keep every flop updating from pre-edge values.
      state_q   <= state_d;
      div_cnt_q <= div_cnt_d;
    end
  end

  always_comb begin
    // NOTE: defaults first so no path through this block can infer a latch.
    state_d   = state_q;
    div_cnt_d = div_cnt_q;
    case (state_q)
      RUN: begin
        // A divide only issues when it is not wrong-path and not itself stalled.
        if (id_is_div && !ex_branch_taken && imem_ready && !load_use) begin
          state_d   = DIV_WAIT;
          div_cnt_d = DIV_CNT_INIT;
        end
      end
      DIV_WAIT: begin
        if (div_cnt_q == 8'd0) state_d = RUN;
        else                   div_cnt_d = div_cnt_q - 8'd1;
      end
      default: state_d = RUN;
    endcase
  end

  always_comb begin
    pc_hold     = 1'b0;
    ifid_hold   = 1'b0;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    div_busy    = 1'b0;
    div_done    = 1'b0;
    if (reset) begin
      if ((state_q == RUN) && ex_branch_taken) begin
        ifid_flush  = 1'b1;
        idex_bubble = 1'b1;
      end else if (state_q == DIV_WAIT) begin
        pc_hold     = 1'b1;
        ifid_hold   = 1'b1;
        idex_bubble = 1'b1;
        div_busy    = 1'b1;
        div_done    = (div_cnt_q == 8'd0);
      end else if (!imem_ready || load_use) begin
        pc_hold     = 1'b1;
        ifid_hold   = 1'b1;
        idex_bubble = 1'b1;
      end
    end
  end

  always_comb begin
    stall_count_d = stall_count_q;
    if (perf_clear)
      stall_count_d = '0;
    else if (pc_hold && (stall_count_q != '1))
      stall_count_d = stall_count_q + CNT_W'(1);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) stall_count_q <= '0;
    else        stall_count_q <= stall_count_d;
  end

  assign stall_count = stall_count_q;

endmodule
